apb_master_n: RTL and testbench
===============================

APB_MASTER_N -- requirements
Module: apb_master_n

Interface
REQ-001 Parameter NUM_SLV, default 5: number of APB slave ports, range 1..16.
REQ-002 Parameter BASE_ADDR, default 32'h1000_0000: start of the decoded peripheral window.
REQ-003 Parameter SLV_SHIFT, default 12: log2 of bytes per slave region (4 KB regions by default).
REQ-004 Parameter TIMEOUT, default 16: maximum ACCESS-phase cycles before abort; 0 disables the timeout.
REQ-005 PCLK  in  1: single clock; all state updates on the rising edge.
REQ-006 PRESET  in  1: reset, synchronous and active-high.
REQ-007 PADDR  out  32: latched transfer address.
REQ-008 PWRITE  out  1: latched direction, 1 = write.
REQ-009 PENABLE  out  1: ACCESS-phase indicator.
REQ-010 PWDATA  out  32: latched write data.
REQ-011 PSEL  out  NUM_SLV: one-hot slave select; bit i selects slave i.
REQ-012 PRDATA  in  32*NUM_SLV: slave read data; slave i occupies bits [32*i+31:32*i].
REQ-013 PREADY  in  NUM_SLV: per-slave ready.
REQ-014 PSLVERR  in  NUM_SLV: per-slave error response.
REQ-015 transfer  in  1: request strobe from the core side.
REQ-016 write  in  1: request direction.
REQ-017 addr  in  32: request address.
REQ-018 wdata  in  32: request write data.
REQ-019 ready  out  1: one-cycle completion pulse.
REQ-020 rdata  out  32: read data, valid while ready = 1.
REQ-021 error  out  1: error flag, valid while ready = 1.

Function
REQ-022 The FSM SHALL have exactly three states: IDLE, SETUP and ACCESS.
REQ-023 In IDLE, transfer = 1 at a clock edge SHALL latch addr, write and wdata and move the FSM to SETUP; transfer SHALL be ignored in SETUP and ACCESS.
REQ-024 PADDR, PWRITE and PWDATA SHALL always equal the latched values, and SHALL be stable through SETUP and ACCESS.
REQ-025 Decode SHALL be hit when PADDR >= BASE_ADDR and idx = (PADDR - BASE_ADDR) >> SLV_SHIFT < NUM_SLV; all other addresses are a miss.
REQ-026 On a hit, PSEL[idx] SHALL be 1 in SETUP and ACCESS; all other PSEL bits SHALL be 0, and all PSEL bits SHALL be 0 in IDLE.
REQ-027 PENABLE SHALL be 1 only in ACCESS.
REQ-028 SETUP on a hit SHALL always last one cycle and then go to ACCESS.
REQ-029 SETUP on a miss SHALL assert no PSEL, SHALL return to IDLE, and SHALL produce a response with error = 1 and rdata = 0.
REQ-030 In ACCESS, PREADY[idx] = 1 at an edge SHALL complete the transfer, return the FSM to IDLE, and register rdata = PRDATA slice idx (reads; 0 for writes) and error = PSLVERR[idx].
REQ-031 PREADY and PSLVERR from unselected slaves SHALL be ignored.
REQ-032 With TIMEOUT > 0, the ACCESS cycle counter SHALL be cleared on entering ACCESS and incremented each ACCESS cycle.
REQ-033 When the counter reaches TIMEOUT with PREADY[idx] still 0, the transfer SHALL be aborted: FSM to IDLE, error = 1, rdata = 0.
REQ-034 If PREADY arrives in the same cycle as the timeout, PREADY SHALL win.
REQ-035 ready, rdata and error SHALL be registered; ready SHALL be high for exactly the one cycle after the completing edge, i.e. the first IDLE cycle.
REQ-036 rdata and error SHALL be 0 whenever ready = 0.
REQ-037 A transfer asserted during the ready cycle SHALL be accepted, giving back-to-back operation.
REQ-038 Zero-wait hit latency SHALL be: transfer sampled at edge k, SETUP in cycle k+1, ACCESS in k+2, ready in k+3.
REQ-039 Miss latency SHALL be: ready in cycle k+2.

Reset
REQ-040 PRESET = 1 at an edge SHALL, in any state including mid-transfer, force IDLE and clear PSEL, PENABLE, ready, error, rdata, the latched address/data/direction registers and the timeout counter to 0.
REQ-041 An interrupted transfer SHALL produce no ready pulse.

Verification
REQ-042 Zero-wait write: addr 1000_1004, wdata A5A5_A5A5, PREADY[1] = 1 -> PSEL = 00010 for 2 cycles, PENABLE 1 cycle, ready at k+3, error = 0.
REQ-043 Read with 3 wait states: addr 1000_3000, PRDATA3 = 1234_5678 -> ready at k+6, rdata = 1234_5678, error = 0.
REQ-044 Unmapped addresses: addr 1000_5000 and addr 0FFF_FFFC -> PSEL never asserted, ready at k+2 with error = 1 and rdata = 0.
REQ-045 Timeout: PREADY[0] held at 0, TIMEOUT = 16 -> abort after 16 ACCESS cycles, ready with error = 1; PREADY on the 16th cycle instead -> normal completion.
REQ-046 Back-to-back and error response: second transfer asserted in the ready cycle is accepted with no idle gap; PSLVERR[2] = 1 with PREADY -> error = 1.
REQ-047 Reset during ACCESS -> next cycle all outputs 0, no ready pulse.

Source files
------------

// File: rtl/apb_master_n.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_n
// Purpose  : APB bridge from a simple core-side request strobe to NUM_SLV
//            APB slaves. The slave is chosen by address decode. An optional
//            access-phase timeout aborts transfers to slaves that never
//            answer.
// Ports    : PCLK/PRESET    - clock, synchronous active-high reset
//            PADDR/PWRITE/PWDATA/PENABLE/PSEL - APB request side
//            PRDATA/PREADY/PSLVERR          - per-slave APB response buses
//            transfer/write/addr/wdata      - core request (sampled in IDLE)
//            ready/rdata/error              - registered one-cycle response
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_n #(
  parameter int          NUM_SLV   = 5,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          SLV_SHIFT = 12,
  parameter int          TIMEOUT   = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  output logic [31:0]             PADDR,
  output logic                    PWRITE,
  output logic                    PENABLE,
  output logic [31:0]             PWDATA,
  output logic [NUM_SLV-1:0]      PSEL,
  input  logic [32*NUM_SLV-1:0]   PRDATA,
  input  logic [NUM_SLV-1:0]      PREADY,
  input  logic [NUM_SLV-1:0]      PSLVERR,
  input  logic                    transfer,
  input  logic                    write,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  output logic                    ready,
  output logic [31:0]             rdata,
  output logic                    error
);

  // The counter only has to reach TIMEOUT-1; the abort fires on that cycle.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_paddr;
  logic [31:0]        r_pwdata;
  logic               r_pwrite;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ready;
  logic [31:0]        r_rdata;
  logic               r_error;

  logic [31:0]        w_offset;
  logic [31:0]        w_slot;
  logic               w_hit;
  logic [NUM_SLV-1:0] w_dec;
  logic [31:0]        w_sel_rdata;
  logic               w_sel_ready;
  logic               w_sel_err;
  logic               w_timeout;
  logic               w_done;
  logic               w_abort;

  // ---------------------------------------------------------------------------
  // Address decode from the latched address. The subtraction wraps for
  // addresses below the window, so the lower-bound compare is kept explicit.
  // ---------------------------------------------------------------------------
  assign w_offset = r_paddr - BASE_ADDR;
  assign w_slot   = w_offset >> SLV_SHIFT;
  assign w_hit    = (r_paddr >= BASE_ADDR) && (w_slot < 32'(NUM_SLV));

  generate
    for (genvar i = 0; i < NUM_SLV; i++) begin : g_dec
      assign w_dec[i] = w_hit && (w_slot == 32'(i));
    end
  endgenerate

  // One-hot mux of the selected slave's response; unselected slaves are masked.
  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (w_dec[i]) begin
        w_sel_rdata = PRDATA[32*i +: 32];
      end
    end
  end

  assign w_sel_ready = |(PREADY & w_dec);
  assign w_sel_err   = |(PSLVERR & w_dec);
  assign w_timeout   = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and completion qualifiers
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (transfer) begin
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_hit) begin
          w_state_nxt = S_ACCESS;
        end else begin
          w_state_nxt = S_IDLE;
          w_abort     = 1'b1;
        end
      end
      S_ACCESS: begin
        // A ready arriving on the timeout cycle takes priority over the abort.
        if (w_sel_ready) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_abort     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch, access counter and registered response
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
      r_cnt    <= '0;
      r_ready  <= 1'b0;
      r_rdata  <= '0;
      r_error  <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && transfer) begin
        r_paddr  <= addr;
        r_pwdata <= wdata;
        r_pwrite <= write;
      end

      // Held at zero outside ACCESS, so it starts from zero on every entry.
      if (r_state == S_ACCESS) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end

      r_ready <= w_done | w_abort;
      r_error <= w_abort | (w_done & w_sel_err);
      r_rdata <= (w_done && !r_pwrite) ? w_sel_rdata : '0;
    end
  end

  assign PADDR   = r_paddr;
  assign PWDATA  = r_pwdata;
  assign PWRITE  = r_pwrite;
  assign PENABLE = (r_state == S_ACCESS);
  assign PSEL    = ((r_state == S_SETUP) || (r_state == S_ACCESS)) ? w_dec : '0;
  assign ready   = r_ready;
  assign rdata   = r_rdata;
  assign error   = r_error;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_n
// Purpose  : Self-checking bench for apb_master_n. Stimulus pushes the
//            expected response (completion cycle, rdata, error) into a queue.
//            A negedge monitor pops an entry and compares it on every ready
//            pulse. Slaves are modelled with per-slave wait states, error and
//            read data. Unselected slaves drive PREADY=1 and PSLVERR=1 so that
//            any leakage through the select mask is visible.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_n;

  localparam int NS = 5;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic              clk = 1'b0;
  logic              preset;
  logic [31:0]       paddr;
  logic              pwrite;
  logic              penable;
  logic [31:0]       pwdata;
  logic [NS-1:0]     psel;
  logic [32*NS-1:0]  prdata;
  logic [NS-1:0]     pready;
  logic [NS-1:0]     pslverr;
  logic              transfer;
  logic              write;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              ready;
  logic [31:0]       rdata;
  logic              error;

  int                wait_cfg [NS];
  logic              err_cfg  [NS];
  logic [31:0]       data_cfg [NS];
  int                acc = 0;
  int                cyc = 0;
  int                n_tests = 0;
  int                n_fail = 0;
  exp_t              q[$];

  always #5 clk = ~clk;

  apb_master_n #(
    .NUM_SLV   (NS),
    .BASE_ADDR (32'h1000_0000),
    .SLV_SHIFT (12),
    .TIMEOUT   (16)
  ) dut (
    .PCLK     (clk),
    .PRESET   (preset),
    .PADDR    (paddr),
    .PWRITE   (pwrite),
    .PENABLE  (penable),
    .PWDATA   (pwdata),
    .PSEL     (psel),
    .PRDATA   (prdata),
    .PREADY   (pready),
    .PSLVERR  (pslverr),
    .transfer (transfer),
    .write    (write),
    .addr     (addr),
    .wdata    (wdata),
    .ready    (ready),
    .rdata    (rdata),
    .error    (error)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Index of the current ACCESS cycle (0 for the first one).
  always @(posedge clk) acc <= penable ? acc + 1 : 0;

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      prdata[32*i +: 32] = data_cfg[i];
      if (psel[i] && penable) begin
        pready[i]  = (acc >= wait_cfg[i]);
        pslverr[i] = err_cfg[i];
      end else begin
        pready[i]  = 1'b1;
        pslverr[i] = 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (ready === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ready: got ready=1 with no transfer pending (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("ready_cycle", 32'(cyc), 32'(e.cyc));
        chk("resp_rdata", rdata, e.rdata);
        chk("resp_error", {31'd0, error}, {31'd0, e.err});
      end
    end else if (!preset) begin
      chk("idle_rdata_zero", rdata, 32'd0);
      chk("idle_error_zero", {31'd0, error}, 32'd0);
    end
  end

  // Called at a negedge; returns at the negedge of the SETUP cycle.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input int lat, input logic [31:0] er, input logic ee, input logic push);
    exp_t e;
    transfer = 1'b1;
    write    = wr;
    addr     = a;
    wdata    = d;
    e.cyc    = cyc + 1 + lat;
    e.rdata  = er;
    e.err    = ee;
    if (push) q.push_back(e);
    @(negedge clk);
    // Scramble the request inputs to show the latched copy is used.
    transfer = 1'b0;
    write    = ~wr;
    addr     = 32'hFFFF_FFFF;
    wdata    = ~d;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_ready: got ready=0 expected 1 within %0d cycles", n);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_psel"}, 32'(psel), 32'd0);
    chk({tag, "_penable"}, {31'd0, penable}, 32'd0);
    chk({tag, "_ready"}, {31'd0, ready}, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_paddr"}, paddr, 32'd0);
    chk({tag, "_pwdata"}, pwdata, 32'd0);
    chk({tag, "_pwrite"}, {31'd0, pwrite}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      wait_cfg[i] = 0;
      err_cfg[i]  = 1'b0;
      data_cfg[i] = 32'h1111_0000 + 32'(i);
    end
    preset   = 1'b1;
    transfer = 1'b0;
    write    = 1'b0;
    addr     = '0;
    wdata    = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    preset = 1'b0;
    @(negedge clk);

    // Zero-wait write to slave 1, phase by phase.
    issue(1'b1, 32'h1000_1004, 32'hA5A5_A5A5, 2, 32'd0, 1'b0, 1'b1);
    chk("wr_setup_psel", 32'(psel), 32'h02);
    chk("wr_setup_penable", {31'd0, penable}, 32'd0);
    chk("wr_setup_paddr", paddr, 32'h1000_1004);
    chk("wr_setup_pwdata", pwdata, 32'hA5A5_A5A5);
    @(negedge clk);
    chk("wr_access_psel", 32'(psel), 32'h02);
    chk("wr_access_penable", {31'd0, penable}, 32'd1);
    chk("wr_access_pwrite", {31'd0, pwrite}, 32'd1);
    wait_ready();
    chk("wr_done_psel", 32'(psel), 32'd0);
    chk("wr_done_penable", {31'd0, penable}, 32'd0);
    @(negedge clk);

    // Read from slave 3 with three wait states.
    wait_cfg[3] = 3;
    data_cfg[3] = 32'h1234_5678;
    issue(1'b0, 32'h1000_3000, 32'd0, 5, 32'h1234_5678, 1'b0, 1'b1);
    chk("rd3_setup_psel", 32'(psel), 32'h08);
    wait_ready();
    @(negedge clk);

    // Unmapped: just past the last slave and just below the window.
    issue(1'b0, 32'h1000_5000, 32'd0, 1, 32'd0, 1'b1, 1'b1);
    chk("miss_hi_psel", 32'(psel), 32'd0);
    wait_ready();
    chk("miss_hi_psel_done", 32'(psel), 32'd0);
    @(negedge clk);
    issue(1'b1, 32'h0FFF_FFFC, 32'h5555_AAAA, 1, 32'd0, 1'b1, 1'b1);
    chk("miss_lo_psel", 32'(psel), 32'd0);
    wait_ready();
    @(negedge clk);

    // Timeout abort: slave 0 never ready, 16 ACCESS cycles.
    wait_cfg[0] = 255;
    issue(1'b0, 32'h1000_0000, 32'd0, 17, 32'd0, 1'b1, 1'b1);
    wait_ready();
    @(negedge clk);

    // Ready on the 16th ACCESS cycle wins over the timeout.
    wait_cfg[0] = 15;
    data_cfg[0] = 32'hCAFE_F00D;
    issue(1'b0, 32'h1000_0FFC, 32'd0, 17, 32'hCAFE_F00D, 1'b0, 1'b1);
    wait_ready();
    @(negedge clk);

    // Back-to-back: each new request is issued during the previous ready cycle.
    data_cfg[4] = 32'hDEAD_BEEF;
    issue(1'b0, 32'h1000_4010, 32'd0, 2, 32'hDEAD_BEEF, 1'b0, 1'b1);
    wait_ready();
    wait_cfg[2] = 1;
    err_cfg[2]  = 1'b1;
    data_cfg[2] = 32'h0000_55AA;
    issue(1'b1, 32'h1000_2008, 32'h0F0F_0F0F, 3, 32'd0, 1'b1, 1'b1);
    chk("b2b_setup_psel", 32'(psel), 32'h04);
    wait_ready();
    issue(1'b0, 32'h1000_2000, 32'd0, 3, 32'h0000_55AA, 1'b1, 1'b1);
    wait_ready();
    err_cfg[2] = 1'b0;
    @(negedge clk);

    // Reset in the middle of ACCESS: no response expected.
    wait_cfg[3] = 255;
    issue(1'b1, 32'h1000_3004, 32'h7777_8888, 0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_mid_penable", {31'd0, penable}, 32'd1);
    preset = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_mid");
    preset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_no_ready", {31'd0, ready}, 32'd0);
    end

    // Recovery after reset.
    data_cfg[1] = 32'h0BAD_F00D;
    issue(1'b0, 32'h1000_1000, 32'd0, 2, 32'h0BAD_F00D, 1'b0, 1'b1);
    wait_ready();
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
